// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of lane-shifted stores that feeds the data memory.
// Define STORE_BUFFER_FWD_EN to add store-to-load byte forwarding; the default build omits it.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_addr,
  input  logic [31:0]            in_data,
  input  logic [3:0]             in_mask,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_data,
  output logic [3:0]             mem_mask,
  input  logic [31:0]            ld_addr,
  output logic [3:0]             ld_fwd_mask,
  output logic [31:0]            ld_fwd_data,
  output logic                   misalign,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  // Word addresses only; the byte offset has already been folded into mask/data.
  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    mask_q [DEPTH];

  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          misalign_q;

  logic [6:0]    mask_wide;
  logic [31:0]   data_shift;
  logic          overflow;
  logic          accept;
  logic          push;
  logic          pop;

  always_comb begin
    mask_wide  = {3'b000, in_mask} << in_addr[1:0];
    data_shift = in_data << {in_addr[1:0], 3'b000};
    overflow   = |mask_wide[6:4];
    in_ready   = rst_n && (count_q < FullCount);
    mem_valid  = rst_n && (count_q != '0);
    accept     = in_valid && in_ready;
    // Misaligned and empty-mask stores still handshake but never occupy an entry.
    push       = accept && !overflow && (in_mask != 4'b0000);
    pop        = mem_valid && mem_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      misalign_q <= accept && overflow;
    end
  end

  // Entry storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr_q] <= in_addr[31:2];
      data_q[wptr_q] <= data_shift;
      mask_q[wptr_q] <= mask_wide[3:0];
    end
  end

  assign mem_addr = {addr_q[rptr_q], 2'b00};
  assign mem_data = data_q[rptr_q];
  assign mem_mask = mask_q[rptr_q];
  assign misalign = misalign_q;
  assign count    = count_q;

`ifdef STORE_BUFFER_FWD_EN
  logic [AW-1:0] fwd_idx;
  logic          unused_ld;

  // Walk oldest to youngest so younger matches overwrite older ones per lane.
  always_comb begin
    ld_fwd_mask = '0;
    ld_fwd_data = '0;
    fwd_idx     = rptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rptr_q + AW'(i);
      if ((CW'(i) < count_q) && (addr_q[fwd_idx] == ld_addr[31:2])) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (mask_q[fwd_idx][b]) begin
            ld_fwd_mask[b]        = 1'b1;
            ld_fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
    if (!rst_n) begin
      ld_fwd_mask = '0;
      ld_fwd_data = '0;
    end
  end

  assign unused_ld = ^ld_addr[1:0];
`else
  logic unused_ld;

  assign ld_fwd_mask = '0;
  assign ld_fwd_data = '0;
  assign unused_ld   = ^ld_addr;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH = 4).
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_mask = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_mask;
  logic [31:0] ld_addr = '0;
  logic [3:0]  ld_fwd_mask;
  logic [31:0] ld_fwd_data;
  logic        misalign;
  logic [2:0]  count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  logic [31:0] nxt;
  logic        acc;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_mask    (in_mask),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_mask   (mem_mask),
    .ld_addr    (ld_addr),
    .ld_fwd_mask(ld_fwd_mask),
    .ld_fwd_data(ld_fwd_data),
    .misalign   (misalign),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_mask  = m;
    step();
    in_valid = 1'b0;
  endtask

  // One cycle of word-aligned full-word traffic tracked by the queue model.
  task automatic tick(output logic accepted);
    logic pp;
    accepted = in_valid && (q.size() < DEPTH);
    pp       = mem_ready && (q.size() > 0);
    step();
    if (pp) void'(q.pop_front());
    if (accepted) q.push_back(in_data);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_fwd_mask", 32'(ld_fwd_mask), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_mem_valid", 32'(mem_valid), 32'd0);
    @(negedge clk);

    // Byte store at offset 3
    put(32'h0000_1003, 32'h0000_00AB, 4'b0001);
    check("b3_mem_valid", 32'(mem_valid), 32'd1);
    check("b3_mem_addr", mem_addr, 32'h0000_1000);
    check("b3_mem_mask", 32'(mem_mask), 32'h8);
    check("b3_mem_data", mem_data, 32'hAB00_0000);
    check("b3_count", 32'(count), 32'd1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("b3_popped", 32'(count), 32'd0);

    // Half store at offset 2
    put(32'h0000_2002, 32'h0000_BEEF, 4'b0011);
    check("h2_mem_mask", 32'(mem_mask), 32'hC);
    check("h2_mem_data", mem_data, 32'hBEEF_0000);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;

    // Misaligned half store
    put(32'h0000_2003, 32'h0000_1234, 4'b0011);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_count", 32'(count), 32'd0);
    check("mis_mem_valid", 32'(mem_valid), 32'd0);
    step();
    check("mis_one_cycle", 32'(misalign), 32'd0);
    put(32'h0000_2002, 32'hFFFF_FFFF, 4'b1111);
    check("mis_word", 32'(misalign), 32'd1);
    check("mis_word_count", 32'(count), 32'd0);

    // Empty mask: handshake, no entry
    put(32'h0000_2001, 32'h0000_0077, 4'b0000);
    check("m0_count", 32'(count), 32'd0);
    check("m0_misalign", 32'(misalign), 32'd0);

    // Fill to full, hold, then drain in order
    in_mask = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_addr  = 32'h100 + 32'(4 * i);
      in_data  = 32'hA0 + 32'(i);
      tick(acc);
    end
    in_valid = 1'b0;
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    step();
    step();
    check("hold_data", mem_data, 32'hA0);
    check("hold_addr", mem_addr, 32'h100);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_head", mem_data, 32'hA0 + 32'(i));
      check("drain_addr", mem_addr, 32'h100 + 32'(4 * i));
      tick(acc);
    end
    mem_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", 32'(mem_valid), 32'd0);

    // Sustained traffic across pointer wrap
    in_addr = 32'h400;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hC0 + 32'(i);
      tick(acc);
    end
    nxt       = 32'hD0;
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = nxt;
      check("wrap_head", mem_data, q[0]);
      check("wrap_count", 32'(count), 32'(q.size()));
      tick(acc);
      if (acc) nxt = nxt + 32'd1;
    end
    mem_ready = 1'b0;
    in_data   = nxt;
    tick(acc);
    in_valid = 1'b0;
    check("refill_count", 32'(count), 32'd4);
    check("refill_in_ready", 32'(in_ready), 32'd0);
    check("refill_head", mem_data, 32'hD6);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("wrap_drain", mem_data, 32'hD6 + 32'(i));
      tick(acc);
    end
    mem_ready = 1'b0;
    check("wrap_empty", 32'(count), 32'd0);

    // Forwarding
    put(32'h0000_3000, 32'h1122_3344, 4'b1111);
    put(32'h0000_3001, 32'h0000_0055, 4'b0001);
    ld_addr = 32'h0000_3000;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    check("fwd_mask", 32'(ld_fwd_mask), 32'hF);
    check("fwd_data", ld_fwd_data, 32'h1122_5544);
`else
    check("fwd_mask", 32'(ld_fwd_mask), 32'h0);
    check("fwd_data", ld_fwd_data, 32'h0);
`endif
    ld_addr = 32'h0000_3004;
    #1;
    check("fwd_miss_mask", 32'(ld_fwd_mask), 32'h0);
    @(negedge clk);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("fwd_head_mask", 32'(mem_mask), 32'h2);
    check("fwd_head_data", mem_data, 32'h0000_5500);
    ld_addr = 32'h0000_3000;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    check("fwd_after_pop_mask", 32'(ld_fwd_mask), 32'h2);
    check("fwd_after_pop_data", ld_fwd_data, 32'h0000_5500);
`else
    check("fwd_after_pop_mask", 32'(ld_fwd_mask), 32'h0);
    check("fwd_after_pop_data", ld_fwd_data, 32'h0);
`endif
    @(negedge clk);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("fwd_empty", 32'(count), 32'd0);

    // Reset mid-occupancy
    q.delete();
    in_addr = 32'h500;
    in_mask = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hE0 + 32'(i);
      tick(acc);
    end
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd3);
    rst_n   = 1'b0;
    ld_addr = 32'h500;
    step();
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_fwd_mask", 32'(ld_fwd_mask), 32'd0);
    check("mid_rst_fwd_data", ld_fwd_data, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_mem_valid", 32'(mem_valid), 32'd0);
    step();
    check("post_rst_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
